// File: rtl/pll_reset_ce_gen.sv
// Post-PLL reset sequencer: synchronises the lock flag, holds the core in reset until lock
// has been stable, stretches soft resets, tracks loss of lock and generates phase-aligned CEs.
module pll_reset_ce_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_HOLD   = 1024,
   parameter int RESET_HOLD  = 16,
   parameter int CE_DIV_A    = 4,
   parameter int CE_DIV_B    = 8
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       soft_reset,
   input  logic       lock_lost_clr,
   output logic       core_reset,
   output logic       ce_a,
   output logic       ce_b,
   output logic [1:0] state,
   output logic       lock_lost
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_SOFT = 2'd3
   } state_t;

   localparam int CNT_MAX = (LOCK_HOLD > RESET_HOLD) ? LOCK_HOLD : RESET_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int A_W     = $clog2(CE_DIV_A);
   localparam int B_W     = $clog2(CE_DIV_B);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(RESET_HOLD - 1);
   localparam logic [A_W-1:0]   A_LAST    = A_W'(CE_DIV_A - 1);
   localparam logic [B_W-1:0]   B_LAST    = B_W'(CE_DIV_B - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;
   state_t                 r_state, w_state_next;
   logic [CNT_W-1:0]       r_cnt, w_cnt_next;
   logic                   w_lost_set;
   logic                   r_core_reset;
   logic                   r_lock_lost;
   logic [A_W-1:0]         r_div_a;
   logic [B_W-1:0]         r_div_b;
   logic                   r_ce_a, r_ce_b;

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk_sys) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_lost_set   = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (w_locked_s) begin
               w_state_next = ST_HOLD;
               w_cnt_next   = '0;
            end
         end
         ST_HOLD: begin
            if (!w_locked_s) begin
               w_state_next = ST_WAIT;
               w_cnt_next   = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_next = ST_RUN;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (!w_locked_s) begin
               w_state_next = ST_WAIT;
               w_cnt_next   = '0;
               w_lost_set   = 1'b1;
            end else if (soft_reset) begin
               w_state_next = ST_SOFT;
               w_cnt_next   = '0;
            end
         end
         ST_SOFT: begin
            // Counter saturates so a long-held request keeps us here without wrapping.
            if (!w_locked_s) begin
               w_state_next = ST_WAIT;
               w_cnt_next   = '0;
               w_lost_set   = 1'b1;
            end else if (r_cnt == SOFT_LAST) begin
               if (!soft_reset) w_state_next = ST_RUN;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_WAIT;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state      <= ST_WAIT;
         r_cnt        <= '0;
         r_core_reset <= 1'b1;
         r_lock_lost  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_core_reset <= (w_state_next != ST_RUN);
         // A new loss of lock beats a simultaneous clear.
         if (w_lost_set)         r_lock_lost <= 1'b1;
         else if (lock_lost_clr) r_lock_lost <= 1'b0;
      end
   end

   // Dividers run in every FSM state so the core's synchronous resets still see enables.
   always_ff @(posedge clk_sys) begin
      if (rst || !w_locked_s) begin
         r_div_a <= '0;
         r_div_b <= '0;
         r_ce_a  <= 1'b0;
         r_ce_b  <= 1'b0;
      end else begin
         r_div_a <= (r_div_a == A_LAST) ? '0 : r_div_a + 1'b1;
         r_div_b <= (r_div_b == B_LAST) ? '0 : r_div_b + 1'b1;
         r_ce_a  <= (r_div_a == A_LAST);
         r_ce_b  <= (r_div_b == B_LAST);
      end
   end

   assign core_reset = r_core_reset;
   assign ce_a       = r_ce_a;
   assign ce_b       = r_ce_b;
   assign state      = r_state;
   assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Directed bench for pll_reset_ce_gen with LOCK_HOLD=8, so release lands on edge 11
// after the first edge that samples pll_locked high.
module tb_pll_reset_ce_gen;

   localparam logic [1:0] S_WAIT = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_SOFT = 2'd3;

   logic       clk_sys = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_reset = 1'b0;
   logic       lock_lost_clr = 1'b0;
   logic       core_reset, ce_a, ce_b, lock_lost;
   logic [1:0] state;

   int pass_cnt = 0;
   int total_cnt = 0;
   int edge_n = 0;

   pll_reset_ce_gen #(
      .SYNC_STAGES(2), .LOCK_HOLD(8), .RESET_HOLD(16), .CE_DIV_A(4), .CE_DIV_B(8)
   ) dut (
      .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .soft_reset(soft_reset),
      .lock_lost_clr(lock_lost_clr), .core_reset(core_reset), .ce_a(ce_a), .ce_b(ce_b),
      .state(state), .lock_lost(lock_lost)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick;
      @(posedge clk_sys);
      #1;
      edge_n++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      pll_locked = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (core_reset !== 1'b1) $display("FAIL reset_core_reset got=%b exp=1", core_reset);
      else pass_cnt++;
      total_cnt++;
      if (state !== S_WAIT) $display("FAIL reset_state got=%0d exp=%0d", state, S_WAIT);
      else pass_cnt++;
      total_cnt++;
      if ({ce_a, ce_b} !== 2'b00) $display("FAIL reset_ce got=%b%b exp=00", ce_a, ce_b);
      else pass_cnt++;
      total_cnt++;
      if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost got=%b exp=0", lock_lost);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   // Raise lock from a cleared synchroniser and follow the release sequence to edge 12.
   task automatic test_lockup(input string tag);
      logic [1:0] exp_st;
      pll_locked = 1'b1;
      edge_n = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp_st = (e < 3) ? S_WAIT : (e < 11) ? S_HOLD : S_RUN;
         total_cnt++;
         if (core_reset !== (e < 11))
            $display("FAIL %s_core_reset edge=%0d got=%b exp=%b", tag, e, core_reset, (e < 11));
         else pass_cnt++;
         total_cnt++;
         if (state !== exp_st)
            $display("FAIL %s_state edge=%0d got=%0d exp=%0d", tag, e, state, exp_st);
         else pass_cnt++;
      end
   endtask

   task automatic test_ce_align;
      logic exp_a, exp_b, prev_a, prev_b;
      int bad = 0;
      prev_a = ce_a;
      prev_b = ce_b;
      for (int i = 0; i < 64; i++) begin
         tick();
         // locked_s rises after edge 2, so pulses land on edge 6,10,... and 10,18,...
         exp_a = (edge_n >= 6) && (((edge_n - 2) % 4) == 0);
         exp_b = (edge_n >= 10) && (((edge_n - 2) % 8) == 0);
         total_cnt++;
         if ({ce_a, ce_b} !== {exp_a, exp_b}) begin
            $display("FAIL ce_pattern edge=%0d got=%b%b exp=%b%b", edge_n, ce_a, ce_b, exp_a, exp_b);
            bad++;
         end else pass_cnt++;
         if ((ce_b && !ce_a) || (ce_a && prev_a) || (ce_b && prev_b)) bad++;
         prev_a = ce_a;
         prev_b = ce_b;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL ce_alignment got=%0d bad_cycles exp=0", bad);
      else pass_cnt++;
   endtask

   task automatic test_soft_reset;
      soft_reset = 1'b1;
      tick();
      soft_reset = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i > 0) tick();
         total_cnt++;
         if (core_reset !== (i < 16))
            $display("FAIL soft_pulse_core_reset i=%0d got=%b exp=%b", i, core_reset, (i < 16));
         else pass_cnt++;
         total_cnt++;
         if (state !== ((i < 16) ? S_SOFT : S_RUN))
            $display("FAIL soft_pulse_state i=%0d got=%0d", i, state);
         else pass_cnt++;
      end
      soft_reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         total_cnt++;
         if (core_reset !== 1'b1) $display("FAIL soft_held_core_reset i=%0d got=%b exp=1", i, core_reset);
         else pass_cnt++;
      end
      soft_reset = 1'b0;
      tick();
      total_cnt++;
      if (core_reset !== 1'b0) $display("FAIL soft_held_release got=%b exp=0", core_reset);
      else pass_cnt++;
      total_cnt++;
      if (lock_lost !== 1'b0) $display("FAIL soft_lock_lost got=%b exp=0", lock_lost);
      else pass_cnt++;
   endtask

   task automatic test_lock_loss;
      pll_locked = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         total_cnt++;
         if ({core_reset, lock_lost} !== {(e >= 3), (e >= 3)})
            $display("FAIL loss_core_reset_lost edge=%0d got=%b%b exp=%b%b", e, core_reset, lock_lost,
                     (e >= 3), (e >= 3));
         else pass_cnt++;
         if (e >= 3) begin
            total_cnt++;
            if ({state, ce_a, ce_b} !== {S_WAIT, 2'b00})
               $display("FAIL loss_state_ce edge=%0d got=%0d/%b%b exp=0/00", e, state, ce_a, ce_b);
            else pass_cnt++;
         end
      end
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      total_cnt++;
      if (lock_lost !== 1'b0) $display("FAIL loss_clear got=%b exp=0", lock_lost);
      else pass_cnt++;
      test_lockup("relock");
      pll_locked = 1'b0;
      tick();
      tick();
      lock_lost_clr = 1'b1;
      tick();
      lock_lost_clr = 1'b0;
      total_cnt++;
      if ({core_reset, lock_lost} !== 2'b11)
         $display("FAIL loss_set_beats_clr got=%b%b exp=11", core_reset, lock_lost);
      else pass_cnt++;
      repeat (2) tick();
   endtask

   task automatic test_hold_abort;
      int waits = 0;
      logic [1:0] prev_st;
      prev_st = state;
      pll_locked = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e == 5) pll_locked = 1'b0;
         if (e == 6) pll_locked = 1'b1;
         if (prev_st == S_HOLD && state == S_WAIT) waits++;
         prev_st = state;
         total_cnt++;
         if (core_reset !== (e < 17))
            $display("FAIL abort_core_reset edge=%0d got=%b exp=%b", e, core_reset, (e < 17));
         else pass_cnt++;
         if (e == 4 || e == 8 || e == 9 || e == 17) begin
            total_cnt++;
            if (state !== ((e == 8) ? S_WAIT : (e == 17) ? S_RUN : S_HOLD))
               $display("FAIL abort_state edge=%0d got=%0d", e, state);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (waits != 1) $display("FAIL abort_wait_returns got=%0d exp=1", waits);
      else pass_cnt++;
   endtask

   task automatic test_rst_mid_soft;
      soft_reset = 1'b1;
      tick();
      total_cnt++;
      if ({state, lock_lost} !== {S_SOFT, 1'b1})
         $display("FAIL midsoft_entry got=%0d/%b exp=3/1", state, lock_lost);
      else pass_cnt++;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      total_cnt++;
      if ({state, core_reset, ce_a, ce_b, lock_lost} !== {S_WAIT, 4'b1000})
         $display("FAIL rst_mid_soft got=%0d/%b%b%b%b exp=0/1000", state, core_reset, ce_a, ce_b, lock_lost);
      else pass_cnt++;
      rst = 1'b0;
      soft_reset = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         total_cnt++;
         if (core_reset !== (e < 11))
            $display("FAIL rst_relock edge=%0d got=%b exp=%b", e, core_reset, (e < 11));
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_lockup("lockup");
      test_ce_align();
      test_soft_reset();
      test_lock_loss();
      test_hold_abort();
      test_rst_mid_soft();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
